// File: rtl/seq_det_pkg.sv
// Shared types and elaboration helpers for the parametrised sequence detector.
//   fill_state_t : FILL while collecting samples, ARMED once PAT_W are held
//   calc_div     : system clocks per sample tick, never below 1
//   clog2        : counter width for values 0..value-1, never below 1
package seq_det_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } fill_state_t;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned sample_hz);
    int unsigned d;
    if (sample_hz == 0) return 1;
    d = clk_freq / sample_hz;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Sample-rate tick generator.
//   sys_clk_in  : system clock
//   reset       : asynchronous active-low reset
//   tick        : one-cycle strobe every DIV clocks (every cycle when DIV=1)
//   new_clk_out : toggles on every tick
module seq_tick_gen
  import seq_det_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic sys_clk_in,
  input  logic reset,
  output logic tick,
  output logic new_clk_out
);

  localparam int unsigned     CW   = clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      new_clk_out <= 1'b0;
    end else if (tick) begin
      cnt         <= '0;
      new_clk_out <= ~new_clk_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector.
//   sys_clk_in  : system clock          reset       : async active-low reset
//   data_in     : serial input          pattern     : target, MSB oldest
//   overlap_en  : overlapping matches   clr_count   : sync clear of match_count
//   new_clk_out : toggles per tick      data        : latest sample
//   data_bus    : history, bit0 newest  match       : one-cycle match pulse
//   match_count : saturating count      led         : stretched match indicator
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 10_000_000,
  parameter int unsigned SAMPLE_HZ = 5_000_000,
  parameter int unsigned PAT_W     = 4,
  parameter int unsigned HIST_W    = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LED_HOLD  = 4
) (
  input  logic              sys_clk_in,
  input  logic              reset,
  input  logic              data_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap_en,
  input  logic              clr_count,
  output logic              new_clk_out,
  output logic              data,
  output logic [HIST_W-1:0] data_bus,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              led
);

  localparam int unsigned     DIV       = calc_div(CLK_FREQ, SAMPLE_HZ);
  localparam int unsigned     FW        = clog2(PAT_W + 1);
  localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_W);
  localparam int unsigned     TW        = clog2(LED_HOLD + 1);
  localparam logic [TW-1:0]   HOLD      = TW'(LED_HOLD);

  logic              tick;
  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  win_next;
  logic [FW-1:0]     fill_q, fill_d, fill_inc;
  fill_state_t       state_q, state_d;
  logic              pat_chg;
  logic              hit;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]  count_d;

  seq_tick_gen #(.DIV(DIV)) u_tick (
    .sys_clk_in  (sys_clk_in),
    .reset       (reset),
    .tick        (tick),
    .new_clk_out (new_clk_out)
  );

  // Window as it will look once the current sample has been shifted in.
  assign win_next = {data_bus[PAT_W-2:0], data_in};

  always_comb begin
    pat_chg  = (pattern != pattern_q);
    fill_inc = (state_q == ST_ARMED) ? FILL_FULL : fill_q + 1'b1;
    // A pattern change suppresses detection for this cycle.
    hit      = tick && !pat_chg && (fill_inc == FILL_FULL) && (win_next == pattern_q);

    fill_d = fill_q;
    if (pat_chg) begin
      fill_d = '0;
    end else if (tick) begin
      fill_d = (hit && !overlap_en) ? '0 : fill_inc;
    end
    state_d = (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;

    timer_d = timer_q;
    if (hit) begin
      timer_d = HOLD;
    end else if (tick && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end

    // Clear first, then count, so a clear coinciding with a match yields 1.
    count_d = clr_count ? '0 : match_count;
    if (hit && (count_d != '1)) begin
      count_d = count_d + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      pattern_q   <= '0;
      data_bus    <= '0;
      data        <= 1'b0;
      fill_q      <= '0;
      state_q     <= ST_FILL;
      match       <= 1'b0;
      match_count <= '0;
      timer_q     <= '0;
      led         <= 1'b0;
    end else begin
      pattern_q   <= pattern;
      if (tick) begin
        data_bus <= {data_bus[HIST_W-2:0], data_in};
        data     <= data_in;
      end
      fill_q      <= fill_d;
      state_q     <= state_d;
      match       <= hit;
      match_count <= count_d;
      timer_q     <= timer_d;
      led         <= (timer_d != '0);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (defaults plus a CNT_W=2 copy).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [3:0] pattern = 4'b1011;
  logic       overlap_en = 1'b1;
  logic       clr_count = 1'b0;

  logic       new_clk_out, data, match, led;
  logic [7:0] data_bus, match_count;
  logic       new_clk_out2, data2, match2, led2;
  logic [7:0] data_bus2;
  logic [1:0] match_count2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       m;
    logic       l;
    logic       d;
    logic [7:0] bus;
    int         c8;
    int         c2;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_hist;
  int         m_fill, m_timer, m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .sys_clk_in(clk), .reset(reset), .data_in(data_in), .pattern(pattern),
    .overlap_en(overlap_en), .clr_count(clr_count), .new_clk_out(new_clk_out),
    .data(data), .data_bus(data_bus), .match(match), .match_count(match_count), .led(led)
  );

  seq_detector_param #(.CNT_W(2)) dut_c2 (
    .sys_clk_in(clk), .reset(reset), .data_in(data_in), .pattern(pattern),
    .overlap_en(overlap_en), .clr_count(clr_count), .new_clk_out(new_clk_out2),
    .data(data2), .data_bus(data_bus2), .match(match2), .match_count(match_count2), .led(led2)
  );

  task automatic model_reset();
    m_hist = '0; m_fill = 0; m_timer = 0; m_cnt8 = 0; m_cnt2 = 0;
    sb.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Change pattern just after a tick edge so the following edge carries no sample.
  task automatic set_pattern(input logic [3:0] p);
    pattern = p;
    m_fill = 0;
  endtask

  task automatic send_sample(input logic b, input logic clr);
    exp_t       e;
    logic [3:0] win;
    int         fn;
    logic       old;
    bit         seen;
    win    = {m_hist[2:0], b};
    fn     = (m_fill + 1 > 4) ? 4 : m_fill + 1;
    e.m    = (fn == 4) && (win == pattern);
    m_hist = {m_hist[6:0], b};
    m_fill = (e.m && !overlap_en) ? 0 : fn;
    if (e.m) m_timer = 4;
    else if (m_timer > 0) m_timer--;
    if (clr) begin m_cnt8 = 0; m_cnt2 = 0; end
    if (e.m && m_cnt8 < 255) m_cnt8++;
    if (e.m && m_cnt2 < 3) m_cnt2++;
    e.l = (m_timer != 0); e.d = b; e.bus = m_hist; e.c8 = m_cnt8; e.c2 = m_cnt2;
    sb.push_back(e);

    data_in = b; clr_count = clr;
    old = new_clk_out; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (new_clk_out !== old) seen = 1;
      else begin
        checks++;
        if (match !== 1'b0 || match2 !== 1'b0) begin
          failures++;
          $display("FAIL match_idle got=%b/%b exp=0", match, match2);
        end
      end
    end
    clr_count = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL tick_timeout no new_clk_out toggle within 8 cycles");
      sb.delete();
    end else begin
      e = sb.pop_front();
      if (match !== e.m || match2 !== e.m || led !== e.l || data !== e.d ||
          data_bus !== e.bus || match_count !== 8'(e.c8) || match_count2 !== 2'(e.c2)) begin
        failures++;
        $display("FAIL sample got m=%b/%b l=%b d=%b bus=%b c=%0d/%0d exp m=%b l=%b d=%b bus=%b c=%0d/%0d",
                 match, match2, led, data, data_bus, match_count, match_count2,
                 e.m, e.l, e.d, e.bus, e.c8, e.c2);
      end
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_sample(bits[i], 1'b0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (new_clk_out !== 1'b0 || data !== 1'b0 || data_bus !== 8'h00 || match !== 1'b0 ||
        match_count !== 8'h00 || led !== 1'b0 || match_count2 !== 2'b00 || led2 !== 1'b0) begin
      failures++;
      $display("FAIL %s got clk=%b d=%b bus=%b m=%b c=%0d l=%b c2=%0d exp all 0",
               name, new_clk_out, data, data_bus, match, match_count, led, match_count2);
    end
  endtask

  task automatic test_reset();
    pattern = 4'b1011; overlap_en = 1'b1;
    reset = 1'b0;
    model_reset();
    #12;
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    apply_reset();
    overlap_en = 1'b1;
    send_bits(16'b1011011, 7);
    checks++;
    if (match_count !== 8'd2 || data_bus !== 8'b0101_1011) begin
      failures++;
      $display("FAIL overlap_final got c=%0d bus=%b exp c=2 bus=01011011", match_count, data_bus);
    end
  endtask

  task automatic test_non_overlap();
    apply_reset();
    overlap_en = 1'b0;
    send_bits(16'b1011011, 7);
    checks++;
    if (match_count !== 8'd1) begin
      failures++;
      $display("FAIL non_overlap_count got=%0d exp=1", match_count);
    end
    overlap_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_bits(16'b101, 3);
    #2 reset = 1'b0;
    model_reset();
    #1 check_zero("reset_mid");
    reset = 1'b1;
    send_bits(16'b1011, 4);
  endtask

  task automatic test_pattern_change();
    apply_reset();
    send_bits(16'b1011, 4);
    set_pattern(4'b0110);
    send_bits(16'b0110, 4);
    checks++;
    if (match_count !== 8'd2) begin
      failures++;
      $display("FAIL pattern_change_count got=%0d exp=2", match_count);
    end
  endtask

  task automatic test_saturate_clear();
    apply_reset();
    set_pattern(4'b1111);
    send_bits(16'hFF, 8);
    checks++;
    if (match_count !== 8'd5 || match_count2 !== 2'd3) begin
      failures++;
      $display("FAIL saturate got=%0d/%0d exp=5/3", match_count, match_count2);
    end
    send_sample(1'b1, 1'b1);
    checks++;
    if (match_count !== 8'd1 || match_count2 !== 2'd1) begin
      failures++;
      $display("FAIL clear_on_match got=%0d/%0d exp=1/1", match_count, match_count2);
    end
  endtask

  task automatic test_led();
    apply_reset();
    set_pattern(4'b1011);
    send_bits(16'b1011_0000_0, 9);
    set_pattern(4'b1010);
    send_bits(16'b1010_10_00000, 11);
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_reset_mid();
    test_pattern_change();
    test_saturate_clear();
    test_led();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
